mdu_iter: RTL and testbench

- Multi-cycle multiply/divide unit that owns the HI/LO register pair.
- Serves MULT/MULTU/DIV/DIVU/MTHI/MTLO, which the single-cycle ALU does not execute.
- Sits beside the ALU in EX. The controller issues a `start` request; the EX/stall logic monitors `busy`/`done`.
- Uses an iterative radix-2 datapath: 32 iterations plus 1 sign-fix cycle.

---
 rtl/mdu_iter.sv | 182 ++++++++++++++++++
 tb/tb_mdu_iter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply/divide unit owning the HI/LO pair (32 iterations + sign-fix).
// Optional macro MDU_EARLY_TERM_EN: multiply exits to FIX once the remaining multiplier bits are zero.
module mdu_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplr_q, mplr_d;
  logic               is_div_q, is_div_d;
  logic               qsign_q, qsign_d;
  logic               rsign_q, rsign_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               op_signed;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     rem_ext, diff;
  logic               sub_ok;
  logic [2*WIDTH-1:0] acc_div, acc_mul, acc_neg;
  logic [WIDTH-1:0]   quo, rem, quo_neg, rem_neg;

  assign op_signed = ~op[0];
  assign abs_a     = (op_signed && A[WIDTH-1]) ? -A : A;
  assign abs_b     = (op_signed && B[WIDTH-1]) ? -B : B;

  // Divide: acc holds {remainder, dividend-shifting-into-quotient}; mplr holds the divisor.
  assign rem_ext = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign diff    = rem_ext - {1'b0, mplr_q};
  assign sub_ok  = (rem_ext >= {1'b0, mplr_q});
  assign acc_div = sub_ok ? {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                          : {rem_ext[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

  // Multiply: multiplicand shifts left so a partial product is already aligned if iteration stops early.
  assign acc_mul = acc_q + (mplr_q[0] ? mcand_q : {(2*WIDTH){1'b0}});
  assign acc_neg = -acc_q;
  assign quo     = acc_q[WIDTH-1:0];
  assign rem     = acc_q[2*WIDTH-1:WIDTH];
  assign quo_neg = -quo;
  assign rem_neg = -rem;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplr_d   = mplr_q;
    is_div_d = is_div_q;
    qsign_d  = qsign_q;
    rsign_d  = rsign_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          case (op)
            3'b000, 3'b001, 3'b010, 3'b011: begin
              acc_d    = op[1] ? {{WIDTH{1'b0}}, abs_a} : '0;
              mcand_d  = {{WIDTH{1'b0}}, abs_a};
              mplr_d   = abs_b;
              is_div_d = op[1];
              qsign_d  = op_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
              rsign_d  = op_signed & A[WIDTH-1];
              dz_d     = (B == '0);
              cnt_d    = CW'(WIDTH - 1);
              state_d  = CALC;
`ifdef MDU_EARLY_TERM_EN
              if (!op[1] && (abs_b == '0)) state_d = FIX;
`endif
            end
            3'b100: begin
              hi_d   = A;
              done_d = 1'b1;
            end
            3'b101: begin
              lo_d   = A;
              done_d = 1'b1;
            end
            default: ;
          endcase
        end
      end

      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          if (is_div_q) begin
            acc_d = acc_div;
          end else begin
            acc_d   = acc_mul;
            mcand_d = mcand_q << 1;
            mplr_d  = mplr_q >> 1;
          end
          if (cnt_q == '0) begin
            state_d = FIX;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
`ifdef MDU_EARLY_TERM_EN
          if (!is_div_q && (mplr_q[WIDTH-1:1] == '0)) state_d = FIX;
`endif
        end
      end

      FIX: begin
        state_d = IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (is_div_q) begin
            // Divide-by-zero keeps the all-ones quotient; the remainder fix restores A.
            lo_d = dz_q ? '1 : (qsign_q ? quo_neg : quo);
            hi_d = rsign_q ? rem_neg : rem;
          end else begin
            {hi_d, lo_d} = qsign_q ? acc_neg : acc_q;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplr_q   <= '0;
      is_div_q <= 1'b0;
      qsign_q  <= 1'b0;
      rsign_q  <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplr_q   <= mplr_d;
      is_div_q <= is_div_d;
      qsign_q  <= qsign_d;
      rsign_q  <= rsign_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: arithmetic reference model with per-cycle compare plus directed literals.
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  always #5 clk = ~clk;

  mdu_iter #(.WIDTH(32)) dut (
    .clk(clk), .rstn(rstn), .start(start), .op(op), .A(A), .B(B),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int mult_lat(input logic [63:0] mag);
`ifdef MDU_EARLY_TERM_EN
    if (mag == 64'd0) return 1;
    for (int i = 63; i >= 0; i--) if (mag[i]) return i + 2;
    return 1;
`else
    return 33;
`endif
  endfunction

  // Results from plain 64-bit arithmetic; latency in clock edges from acceptance to HI/LO update.
  function automatic void ref_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] rh, output logic [31:0] rl, output int lat);
    longint sa, sb, q, r, mag;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    rh = '0; rl = '0; lat = 33;
    case (o)
      3'd0: begin
        p = 64'(sa * sb);
        {rh, rl} = p;
        mag = (sb < 0) ? -sb : sb;
        lat = mult_lat(64'(mag));
      end
      3'd1: begin
        p = {32'd0, a} * {32'd0, b};
        {rh, rl} = p;
        lat = mult_lat({32'd0, b});
      end
      3'd2: begin
        if (b == 32'd0) begin rh = a; rl = 32'hFFFF_FFFF; end
        else begin
          q = sa / sb; r = sa % sb;
          rl = q[31:0]; rh = r[31:0];
        end
      end
      default: begin
        if (b == 32'd0) begin rh = a; rl = 32'hFFFF_FFFF; end
        else begin rl = a / b; rh = a % b; end
      end
    endcase
  endfunction

  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  int          m_left = 0;
  logic        m_done = 1'b0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_hi = '0; m_lo = '0; m_left = 0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        if (flush) m_left = 0;
        else begin
          m_left--;
          if (m_left == 0) begin m_hi = p_hi; m_lo = p_lo; m_done = 1'b1; end
        end
      end else if (start && !flush) begin
        if (op <= 3'd3) ref_op(op, A, B, p_hi, p_lo, m_left);
        else if (op == 3'd4) begin m_hi = A; m_done = 1'b1; end
        else if (op == 3'd5) begin m_lo = A; m_done = 1'b1; end
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", busy, m_left > 0);
    chk("done", done, m_done);
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int k, output int bc);
    k = 0; bc = 0;
    forever begin
      @(negedge clk);
      if (busy) bc++;
      if (done) break;
      if (k >= 100) begin chk("done_timeout", 1, 0); break; end
      @(posedge clk); k++;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

`ifdef MDU_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, bc;
    logic [2:0] o;
    logic [31:0] a, b;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    @(posedge clk); #1 rstn = 1'b1;

    issue(3'd0, 32'hFFFF_FFFD, 32'd7);
    wait_done(k, bc);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFEB);
    chk("mult_lat", k, ET ? 4 : 33);
    chk("mult_busy_cycles", bc, ET ? 4 : 33);

    issue(3'd3, 32'd100, 32'd7);
    wait_done(k, bc);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);
    chk("divu_lat", k, 33);

    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_done(k, bc);
    chk("div_neg_lo", lo, 32'hFFFF_FFFD);
    chk("div_neg_hi", hi, 32'hFFFF_FFFF);

    issue(3'd2, 32'd5, 32'd0);
    wait_done(k, bc);
    chk("div0_lo", lo, 32'hFFFF_FFFF);
    chk("div0_hi", hi, 32'd5);
    chk("div0_lat", k, 33);

    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(k, bc);
    chk("divovf_lo", lo, 32'h8000_0000);
    chk("divovf_hi", hi, 32'd0);

    issue(3'd4, 32'h1234, 32'd0);
    wait_done(k, bc);
    chk("mthi_hi", hi, 32'h1234);
    chk("mthi_lat", k, 0);
    chk("mthi_busy_cycles", bc, 0);

    issue(3'd1, 32'd9, 32'd9);
    repeat (4) @(posedge clk);
    #1 start = 1'b1; op = 3'd1; A = 32'd2; B = 32'd2;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_done", done, 0);
    chk("flush_hi", hi, ET ? 32'd0 : 32'h1234);
    repeat (3) @(negedge clk);
    chk("flush_no_done", done, 0);

    issue(3'd3, 32'd1000, 32'd3);
    repeat (14) @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_hi", hi, 0);
    chk("arst_lo", lo, 0);
    @(posedge clk); #1 rstn = 1'b1;

    issue(3'd1, 32'd6, 32'd7);
    wait_done(k, bc);
    chk("multu67_lo", lo, 32'd42);
    chk("multu67_hi", hi, 32'd0);
    chk("multu67_lat", k, ET ? 4 : 33);

    issue(3'd1, 32'd5, 32'd3);
    wait_done(k, bc);
    chk("multu53_lo", lo, 32'd15);
    chk("multu53_lat", k, ET ? 3 : 33);

    issue(3'd1, 32'd5, 32'd0);
    wait_done(k, bc);
    chk("multu50_lo", lo, 32'd0);
    chk("multu50_lat", k, ET ? 1 : 33);

    issue(3'd6, 32'hDEAD, 32'hBEEF);
    repeat (3) @(negedge clk);
    chk("op11x_no_done", done, 0);

    for (int n = 0; n < 80; n++) begin
      o = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      issue(o, a, b);
      for (int c = 0; c < 40; c++) begin
        @(posedge clk); #1;
        flush = busy && ($urandom_range(0, 79) == 0);
        start = busy && ($urandom_range(0, 7) == 0);
        op = 3'($urandom_range(0, 7));
        A = $urandom;
        B = $urandom;
      end
      flush = 1'b0;
      start = 1'b0;
    end

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
